// File: rtl/fifo_pkg.sv
// Shared helpers and default watermark settings for the FIFO family.
package fifo_pkg;

  localparam int AFULL_MARGIN   = 2;
  localparam int AEMPTY_DEFAULT = 2;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Simple dual-port RAM: one synchronous write port, one registered read port; q updates only on re.
// No reset on the array or on q, so it maps onto block RAM.
module fifo_ram_2p #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] d,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] q
);

  logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= d;
    if (re) q <= mem[raddr];
  end

  // Read-during-write to one address has no defined result here; the FIFO never issues it.
  a_no_rdw_collision : assert property (@(posedge clk) !(we && re && (waddr == raddr)));

endmodule

// File: rtl/sync_fifo_fwft.sv
// FWFT FIFO over a sync-read RAM: a push into an empty FIFO appears on out_data one cycle later.
// in_ready is registered (count < DEPTH); out_data holds while out_ready is low.
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int DWIDTH        = 32,
  parameter int DEPTH         = 16,
  parameter int AWIDTH        = clog2(DEPTH),
  parameter int AFULL_THRESH  = DEPTH - AFULL_MARGIN,
  parameter int AEMPTY_THRESH = AEMPTY_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AWIDTH:0]   count,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam int CW = AWIDTH + 1;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_fwft: DEPTH must be a power of two and at least 4");
  end
  if (AWIDTH != clog2(DEPTH)) begin : g_bad_awidth
    $error("sync_fifo_fwft: AWIDTH is derived from DEPTH and must not be overridden");
  end
  if (AFULL_THRESH > DEPTH || AEMPTY_THRESH >= AFULL_THRESH) begin : g_bad_thresh
    $error("sync_fifo_fwft: almost_full/almost_empty thresholds out of range");
  end

  logic              push;
  logic              pop;
  logic              head_free;
  logic              ram_empty;
  logic              ld_from_in;
  logic              ld_from_ram;
  logic              ram_we;
  logic              ram_re;
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH-1:0] rd_ptr_nxt;
  logic [AWIDTH-1:0] ram_cnt;
  logic [AWIDTH-1:0] ram_left;
  logic [DWIDTH-1:0] ram_q;
  logic [DWIDTH-1:0] byp_data;
  logic              byp_sel;
  logic [AWIDTH:0]   count_nxt;

  // ram_cnt counts entries behind the head; the head is always filled first, so ram_cnt <= DEPTH-1.
  always_comb begin
    push        = in_valid & in_ready;
    pop         = out_valid & out_ready;
    head_free   = !out_valid | pop;
    ram_empty   = (ram_cnt == '0);
    ld_from_in  = push & head_free & ram_empty;
    ld_from_ram = head_free & !ram_empty;
    ram_we      = push & !ld_from_in;
    rd_ptr_nxt  = rd_ptr + AWIDTH'(ld_from_ram);
    ram_left    = ram_cnt - AWIDTH'(ld_from_ram);
    ram_re      = (ram_left != '0);
    count_nxt   = count + CW'(push) - CW'(pop);
  end

  // The RAM is read one cycle ahead at the next head address. When the entry being written
  // becomes the RAM head in the same cycle, reading it would collide, so it is captured in byp_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_cnt      <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      byp_sel      <= 1'b0;
      byp_data     <= '0;
      count        <= '0;
      in_ready     <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (ram_we) wr_ptr <= wr_ptr + AWIDTH'(1);
      rd_ptr  <= rd_ptr_nxt;
      ram_cnt <= ram_left + AWIDTH'(ram_we);

      if (ld_from_in) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else if (ld_from_ram) begin
        out_data  <= byp_sel ? byp_data : ram_q;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end

      byp_sel <= !ram_re & ram_we;
      if (!ram_re && ram_we) byp_data <= in_data;

      count        <= count_nxt;
      in_ready     <= (count_nxt < CW'(DEPTH));
      almost_full  <= (count_nxt >= CW'(AFULL_THRESH));
      almost_empty <= (count_nxt <= CW'(AEMPTY_THRESH));
    end
  end

  fifo_ram_2p #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .d     (in_data),
    .re    (ram_re),
    .raddr (rd_ptr_nxt),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Scoreboarded bench for sync_fifo_fwft: pushes queue expected data, pops compare against the queue.
module tb_sync_fifo_fwft;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  count;
  logic        almost_full;
  logic        almost_empty;

  int          n_vec;
  int          n_err;
  int          n_pops;
  logic [31:0] sb[$];

  sync_fifo_fwft dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 ns after the rising edge; the monitor samples handshakes on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_data = base + 32'(i);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    out_ready = 1'b1;
    while (out_valid && k < 40) begin
      step();
      k++;
    end
    out_ready = 1'b0;
    chk("drain_out_valid", 32'(out_valid), 32'(0));
    chk("drain_sb_empty", 32'(sb.size()), 32'(0));
    chk("drain_count", 32'(count), 32'(0));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_pops++;
        if (sb.size() == 0) chk("pop_with_empty_scoreboard", 32'(1), 32'(0));
        else                chk("pop_data", out_data, sb.pop_front());
      end
      if (in_valid && in_ready) sb.push_back(in_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          k;
    int          pops0;
    int          preload [3];
    int          len [3];

    n_vec     = 0;
    n_err     = 0;
    n_pops    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    preload   = '{1, 2, 5};
    len       = '{20, 20, 100};

    // Reset then idle
    repeat (3) step();
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_almost_empty", 32'(almost_empty), 32'(1));
    chk("rst_almost_full", 32'(almost_full), 32'(0));
    chk("rst_out_data", out_data, 32'(0));
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'(1));

    // Fill to full with flag tracking
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 32'(i);
      step();
      k = i + 1;
      chk("fill_count", 32'(count), 32'(k));
      chk("fill_almost_full", 32'(almost_full), 32'(k >= 14));
      chk("fill_almost_empty", 32'(almost_empty), 32'(k <= 2));
      chk("fill_in_ready", 32'(in_ready), 32'(k < 16));
    end
    in_data = 32'h99;
    step();
    chk("full_push_refused_count", 32'(count), 32'(16));
    chk("full_in_ready", 32'(in_ready), 32'(0));
    chk("full_head", out_data, 32'h0);
    in_valid = 1'b0;
    drain();

    // FWFT latency and hold
    in_valid = 1'b1;
    in_data  = 32'hA5;
    step();
    in_valid = 1'b0;
    chk("fwft_out_valid", 32'(out_valid), 32'(1));
    chk("fwft_out_data", out_data, 32'hA5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fwft_hold_data", out_data, 32'hA5);
      chk("fwft_hold_valid", 32'(out_valid), 32'(1));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("fwft_after_pop_valid", 32'(out_valid), 32'(0));

    // Streaming at several occupancies
    d = 32'h1000;
    for (int s = 0; s < 3; s++) begin
      fill(preload[s], d);
      d = d + 32'(preload[s]);
      chk("stream_preload_count", 32'(count), 32'(preload[s]));
      pops0     = n_pops;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < len[s]; c++) begin
        in_data = d;
        d       = d + 1;
        step();
        chk("stream_count", 32'(count), 32'(preload[s]));
        chk("stream_out_valid", 32'(out_valid), 32'(1));
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("stream_pop_total", 32'(n_pops - pops0), 32'(len[s]));
      drain();
    end

    // Full with simultaneous pop: the push is refused
    fill(16, 32'h200);
    chk("full2_count", 32'(count), 32'(16));
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'h77;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("full_pop_count", 32'(count), 32'(15));
    chk("full_pop_in_ready", 32'(in_ready), 32'(1));
    chk("full_pop_head", out_data, 32'h201);
    drain();

    // Asynchronous reset mid-stream
    fill(9, 32'h300);
    chk("pre_arst_count", 32'(count), 32'(9));
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'(0));
    chk("arst_in_ready", 32'(in_ready), 32'(0));
    chk("arst_count", 32'(count), 32'(0));
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("arst_release_in_ready", 32'(in_ready), 32'(1));
    in_valid = 1'b1;
    in_data  = 32'h3C;
    step();
    in_data = 32'h3D;
    step();
    in_valid = 1'b0;
    chk("arst_first_head", out_data, 32'h3C);
    chk("arst_count_after", 32'(count), 32'(2));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
